// File: rtl/alu8.sv
// 8-bit 6502-style ALU: ADD/SUB/AND/OR/EOR/SR with C/V/Z/N flags, zero-latency combinational outputs.
// Registered copy of result and flags captured every clk edge (1-cycle latency), sync active-low reset; no handshake.
module alu8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [4:0] mode,
  input  logic       carry_in,
  output logic [7:0] alu_out,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero,
  output logic       sign,
  output logic [7:0] result_q,
  output logic [3:0] status_q
);

  localparam logic [4:0] MODE_ADD = 5'd0;
  localparam logic [4:0] MODE_AND = 5'd1;
  localparam logic [4:0] MODE_OR  = 5'd2;
  localparam logic [4:0] MODE_EOR = 5'd3;
  localparam logic [4:0] MODE_SR  = 5'd4;
  localparam logic [4:0] MODE_SUB = 5'd5;

  logic       is_sub;
  logic [7:0] b_eff;
  logic [8:0] sum9;
  logic       sum_ovf;
  logic [7:0] result_d;
  logic [3:0] status_d;

  // SBC is ADC with the operand inverted; overflow test then works on the inverted operand.
  assign is_sub  = (mode == MODE_SUB);
  assign b_eff   = is_sub ? ~alu_b : alu_b;
  assign sum9    = {1'b0, alu_a} + {1'b0, b_eff} + {8'd0, carry_in};
  assign sum_ovf = (alu_a[7] == b_eff[7]) && (sum9[7] != alu_a[7]);

  always_comb begin
    alu_out   = 8'h00;
    carry_out = 1'b0;
    overflow  = 1'b0;
    unique case (mode)
      MODE_ADD, MODE_SUB: begin
        alu_out   = sum9[7:0];
        carry_out = sum9[8];
        overflow  = sum_ovf;
      end
      MODE_AND: alu_out = alu_a & alu_b;
      MODE_OR:  alu_out = alu_a | alu_b;
      MODE_EOR: alu_out = alu_a ^ alu_b;
      MODE_SR: begin
        alu_out   = {carry_in, alu_a[7:1]};
        carry_out = alu_a[0];
      end
      default: begin
        alu_out   = 8'h00;
        carry_out = 1'b0;
        overflow  = 1'b0;
      end
    endcase
  end

  assign zero = (alu_out == 8'h00);
  assign sign = alu_out[7];

  assign result_d = alu_out;
  assign status_d = {sign, overflow, zero, carry_out};

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= 8'h00;
      status_q <= 4'b0000;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_alu8.sv
// Scoreboard bench for alu8: stimulus pushes hand-computed expectations, monitor pops and compares.
// Combinational results checked mid-cycle; registered copies checked one edge later.
module tb_alu8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_a, alu_b;
  logic [4:0] mode;
  logic       carry_in;
  logic [7:0] alu_out;
  logic       carry_out, overflow, zero, sign;
  logic [7:0] result_q;
  logic [3:0] status_q;

  alu8 dut (
    .clk(clk), .reset(reset), .alu_a(alu_a), .alu_b(alu_b), .mode(mode),
    .carry_in(carry_in), .alu_out(alu_out), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .sign(sign),
    .result_q(result_q), .status_q(status_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       c, v, z, n;
  } comb_exp_t;

  typedef struct {
    string      name;
    int         due;
    logic [7:0] r;
    logic [3:0] s;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: half a cycle after each stimulus update, compare whatever is pending.
  always @(negedge clk) begin
    if (comb_q.size() != 0) begin
      comb_exp_t e;
      e = comb_q.pop_front();
      n_cmp++;
      if ({alu_out, carry_out, overflow, zero, sign} !== {e.out, e.c, e.v, e.z, e.n}) begin
        n_bad++;
        $display("FAIL comb %s: got out=%02h c=%b v=%b z=%b n=%b, want out=%02h c=%b v=%b z=%b n=%b",
                 e.name, alu_out, carry_out, overflow, zero, sign, e.out, e.c, e.v, e.z, e.n);
      end
    end
    while (reg_q.size() != 0 && reg_q[0].due <= cyc) begin
      reg_exp_t r;
      r = reg_q.pop_front();
      n_cmp++;
      if ({result_q, status_q} !== {r.r, r.s}) begin
        n_bad++;
        $display("FAIL reg %s: got result_q=%02h status_q=%04b, want result_q=%02h status_q=%04b",
                 r.name, result_q, status_q, r.r, r.s);
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic [4:0] md,
                      input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] eout, input logic ec, input logic ev);
    comb_exp_t ce;
    reg_exp_t  re;
    @(posedge clk);
    #1;
    reset = rst; mode = md; alu_a = a; alu_b = b; carry_in = cin;
    ce.name = name; ce.out = eout; ce.c = ec; ce.v = ev;
    ce.z = (eout == 8'h00); ce.n = eout[7];
    comb_q.push_back(ce);
    re.name = name; re.due = cyc + 1;
    re.r = rst ? eout : 8'h00;
    re.s = rst ? {ce.n, ev, ce.z, ec} : 4'b0000;
    reg_q.push_back(re);
  endtask

  initial begin
    reset = 1'b0; mode = 5'd0; alu_a = 8'h00; alu_b = 8'h00; carry_in = 1'b0;
    //    name               rst mode   a      b      cin  out    C     V
    step("rst0_add_ovf",     0, 5'd0,  8'h50, 8'h50, 0,   8'hA0, 1'b0, 1'b1);
    step("rst1_mode7",       0, 5'd7,  8'h12, 8'h34, 0,   8'h00, 1'b0, 1'b0);
    step("add_wrap_zero",    1, 5'd0,  8'hFF, 8'h01, 0,   8'h00, 1'b1, 1'b0);
    step("add_wrap_cin",     1, 5'd0,  8'hFF, 8'h01, 1,   8'h01, 1'b1, 1'b0);
    step("sub_borrow_ovf",   1, 5'd5,  8'h50, 8'hB0, 1,   8'hA0, 1'b0, 1'b1);
    step("sub_simple",       1, 5'd5,  8'h05, 8'h03, 1,   8'h02, 1'b1, 1'b0);
    step("and_zero",         1, 5'd1,  8'hF0, 8'h0F, 0,   8'h00, 1'b0, 1'b0);
    step("and_zero_cin",     1, 5'd1,  8'hF0, 8'h0F, 1,   8'h00, 1'b0, 1'b0);
    step("or_ff",            1, 5'd2,  8'hF0, 8'h0F, 0,   8'hFF, 1'b0, 1'b0);
    step("or_ff_cin",        1, 5'd2,  8'hF0, 8'h0F, 1,   8'hFF, 1'b0, 1'b0);
    step("eor_55",           1, 5'd3,  8'hAA, 8'hFF, 0,   8'h55, 1'b0, 1'b0);
    step("eor_55_cin",       1, 5'd3,  8'hAA, 8'hFF, 1,   8'h55, 1'b0, 1'b0);
    step("sr_ror",           1, 5'd4,  8'h81, 8'h5A, 1,   8'hC0, 1'b1, 1'b0);
    step("sr_lsr_zero",      1, 5'd4,  8'h01, 8'hFF, 0,   8'h00, 1'b1, 1'b0);
    step("reserved_7",       1, 5'd7,  8'hFF, 8'hFF, 1,   8'h00, 1'b0, 1'b0);
    step("reserved_31",      1, 5'd31, 8'h80, 8'h7F, 0,   8'h00, 1'b0, 1'b0);
    step("reserved_6",       1, 5'd6,  8'h7F, 8'h01, 1,   8'h00, 1'b0, 1'b0);
    step("add_ovf_live",     1, 5'd0,  8'h50, 8'h50, 0,   8'hA0, 1'b0, 1'b1);
    step("midrst_add",       0, 5'd0,  8'h3C, 8'hC3, 0,   8'hFF, 1'b0, 1'b0);
    step("midrst_sub",       0, 5'd5,  8'h10, 8'h01, 1,   8'h0F, 1'b1, 1'b0);
    step("add_7f_01",        1, 5'd0,  8'h7F, 8'h01, 0,   8'h80, 1'b0, 1'b1);
    step("add_80_80",        1, 5'd0,  8'h80, 8'h80, 0,   8'h00, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d comb / %0d reg pending, want 0 / 0", comb_q.size(), reg_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got sim time %0t, want finish before it", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu8.md
# alu8

Combinational 8-bit arithmetic/logic unit for the 6502-compatible CPU core. The unit computes add, subtract, AND, OR, XOR and shift-right results with carry, overflow, zero and sign flags in the same cycle the operands are presented. The CPU datapath consumes the result directly for accumulator updates, indexed-address arithmetic (low byte plus index, high byte plus carry) and pointer increments. A registered copy of the result and flags is also provided, cleared by reset.

## Interface
Parameters:
- None. The datapath is fixed at 8 bits.

Ports:
- `clk`  in  1  System clock. The registered copies are captured on its rising edge.
- `reset`  in  1  Synchronous, active-low reset.
- `alu_a`  in  8  Operand A. Also the shift source.
- `alu_b`  in  8  Operand B.
- `mode`  in  5  Operation select: 0 ADD, 1 AND, 2 OR, 3 EOR, 4 SR, 5 SUB. Codes 6–31 are reserved.
- `carry_in`  in  1  Carry input for ADD and SUB; fill bit for SR.
- `alu_out`  out  8  Combinational result.
- `carry_out`  out  1  Combinational carry flag.
- `overflow`  out  1  Combinational signed-overflow flag.
- `zero`  out  1  Combinational flag; 1 when `alu_out` is 0x00.
- `sign`  out  1  Combinational flag; equals `alu_out[7]`.
- `result_q`  out  8  Registered `alu_out`.
- `status_q`  out  4  Registered flags, ordered `{sign, overflow, zero, carry_out}`.

## Operation
- **ADD (0):** `{carry_out, alu_out} = alu_a + alu_b + carry_in`, a 9-bit sum. `overflow = (a[7] == b[7]) && (out[7] != a[7])`.
- **SUB (1-complement form, 6502 SBC semantics) (5):** `{carry_out, alu_out} = alu_a + ~alu_b + carry_in`.
  - `carry_out = 1` means no borrow.
  - `overflow = (a[7] != b[7]) && (out[7] != a[7])`.
- **AND (1), OR (2), EOR (3):** bitwise operation on `alu_a` and `alu_b`. `carry_out = 0`, `overflow = 0`.
- **SR (4):** `alu_out = {carry_in, alu_a[7:1]}`, `carry_out = alu_a[0]`, `overflow = 0`. `alu_b` is ignored.
  - With `carry_in = 0` this is LSR; with `carry_in = 1` it gives ROR behaviour.
- **Reserved modes 6–31:** `alu_out = 0x00`, `carry_out = 0`, `overflow = 0`. Consequently `zero = 1` and `sign = 0`.
- **Zero and sign flags:** `zero` and `sign` are always derived from the final `alu_out`, in every mode.
- **Width and wrap:** all arithmetic is modulo 256. Carry is the 9th bit of the 9-bit sum.
- **Input sensitivity:** outputs depend only on the current inputs. There is no internal state in the combinational path, and `carry_in` has no effect in AND, OR or EOR modes.

## Timing
- **Combinational path:** `alu_out`, `carry_out`, `overflow`, `zero` and `sign` settle within the same cycle, with zero latency. The path must meet single-cycle timing from operand inputs to CPU register D-inputs.
- **Registered copies:** `result_q` and `status_q` capture the combinational outputs on every rising edge of `clk` while `reset` = 1. There is no enable; latency is 1 cycle.
- **Reset:** when `reset` = 0 at a rising edge, `result_q` becomes 0x00 and `status_q` becomes 4'b0000.
  - Reset takes priority over capture.
  - The combinational outputs are unaffected by reset.
  - The first capture occurs on the first edge with `reset` = 1.
- **Reset mid-stream:** asserting `reset` discards only the registered copy. Combinational results continue to track the inputs.
- **Handshake:** none. There is no valid/ready signalling.

## Test plan
- **ADD signed overflow:** `mode` = 0, a = 0x50, b = 0x50, cin = 0 -> out = 0xA0, C = 0, V = 1, N = 1, Z = 0.
- **ADD wrap to zero:** `mode` = 0, a = 0xFF, b = 0x01, cin = 0 -> out = 0x00, C = 1, V = 0, Z = 1, N = 0. Same operands with cin = 1 -> out = 0x01, C = 1, Z = 0.
- **SUB with borrow and overflow:** `mode` = 5, a = 0x50, b = 0xB0, cin = 1 -> out = 0xA0, C = 0, V = 1, N = 1. With a = 0x05, b = 0x03, cin = 1 -> out = 0x02, C = 1, V = 0.
- **Logic ops:** a = 0xF0, b = 0x0F:
  - AND -> out = 0x00, Z = 1, C = 0, V = 0.
  - OR -> out = 0xFF, N = 1.
  - EOR with a = 0xAA, b = 0xFF -> out = 0x55.
  - Driving cin = 1 changes nothing in these modes.
- **Shift and reserved modes:**
  - SR, a = 0x81, cin = 1 -> out = 0xC0, C = 1, N = 1, V = 0.
  - SR, a = 0x01, cin = 0 -> out = 0x00, C = 1, Z = 1.
  - `mode` = 7 with any inputs -> out = 0x00, Z = 1, C = 0, V = 0, N = 0.
- **Registers and reset:**
  - Hold `reset` = 0 for 2 edges -> `result_q` = 0x00, `status_q` = 0.
  - Release reset and apply ADD 0xFF + 0x01 -> after 1 edge `result_q` = 0x00, `status_q` = 4'b0011.
  - Reassert `reset` = 0 -> `result_q` and `status_q` are 0 after the next edge, while `alu_out` continues to track the inputs.
